// File: rtl/mem_stage_pkg.sv
// Shared types and constants for the MEM pipeline stage.
// Holds the data-memory handshake FSM states and the branch/jump word shift.
package mem_stage_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  localparam int JUMP_SHIFT = 2;

endpackage

// File: rtl/mem_wb.sv
// MEM/WB pipeline register: captures write-back fields, or loads a bubble.
// Latency: one cycle. Backpressure: bubble zeroes control bits and holds data.
module mem_wb (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        bubble,
  input  logic        hold,
  input  logic        mem_to_reg,
  input  logic        reg_write,
  input  logic [31:0] rdata,
  input  logic [31:0] alu,
  input  logic [4:0]  dst,
  output logic        WB_MemtoReg,
  output logic        WB_RegWrite,
  output logic [31:0] WB_ReadData,
  output logic [31:0] WB_ALU,
  output logic [4:0]  WB_Reg_Write
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      WB_MemtoReg  <= 1'b0;
      WB_RegWrite  <= 1'b0;
      WB_ReadData  <= 32'h0;
      WB_ALU       <= 32'h0;
      WB_Reg_Write <= 5'h0;
    end else if (bubble) begin
      WB_MemtoReg  <= 1'b0;
      WB_RegWrite  <= 1'b0;
    end else begin
      WB_MemtoReg  <= mem_to_reg;
      WB_RegWrite  <= reg_write;
      WB_ALU       <= alu;
      WB_Reg_Write <= dst;
      // Load data is only meaningful for loads; keep the last value otherwise.
      if (!hold) WB_ReadData <= rdata;
    end
  end

endmodule

// File: rtl/mem_stage.sv
// MEM stage: data-memory handshake, branch/jump redirect, MEM/WB register.
// Latency: one cycle to WB; stalls upstream until dmem_ack. MEM_ALIGN_CHECK_EN enables misalign trap.
module mem_stage
  import mem_stage_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        MEM_MemtoReg,
  input  logic        MEM_RegWrite,
  input  logic        MEM_Branch,
  input  logic        MEM_Jump,
  input  logic        MEM_MemWrite,
  input  logic        MEM_MemRead,
  input  logic [31:0] MEM_PC,
  input  logic [25:0] MEM_Jump_ins_add,
  input  logic        MEM_Zero,
  input  logic [31:0] MEM_ALU,
  input  logic [31:0] MEM_WriteData,
  input  logic [31:0] MEM_Extimm,
  input  logic [4:0]  MEM_Reg_Write,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack,
  output logic        stall,
  output logic        pc_src,
  output logic [31:0] pc_target,
  output logic        flush,
  output logic        WB_MemtoReg,
  output logic        WB_RegWrite,
  output logic [31:0] WB_ReadData,
  output logic [31:0] WB_ALU,
  output logic [4:0]  WB_Reg_Write,
  output logic        mis_fault
);

  state_t      state, state_nxt;
  logic        mem_op, misaligned, req, is_load;
  logic [31:0] br_target, j_target;

  assign mem_op = MEM_MemRead | MEM_MemWrite;

`ifdef MEM_ALIGN_CHECK_EN
  logic mis_q;

  assign misaligned = mem_op & (MEM_ALU[1:0] != 2'b00);

  always_ff @(posedge clk) begin
    if (!rst_n) mis_q <= 1'b0;
    else        mis_q <= misaligned;
  end

  assign mis_fault = mis_q;
`else
  assign misaligned = 1'b0;
  assign mis_fault  = 1'b0;
`endif

  // A trapped misaligned access never reaches memory and never stalls.
  assign req        = mem_op & ~misaligned;
  assign dmem_req   = req;
  assign dmem_we    = MEM_MemWrite;
  assign dmem_addr  = MEM_ALU;
  assign dmem_wdata = MEM_WriteData;
  assign stall      = req & ~dmem_ack;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req && !dmem_ack) state_nxt = WAIT;
      WAIT:    if (dmem_ack)         state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign br_target = MEM_PC + (MEM_Extimm << JUMP_SHIFT);
  assign j_target  = {MEM_PC[31:28], MEM_Jump_ins_add, 2'b00};
  assign pc_src    = ~stall & (MEM_Jump | (MEM_Branch & MEM_Zero));
  assign pc_target = MEM_Jump ? j_target : br_target;
  assign flush     = pc_src;

  // Read+write together is a store, so no load data is captured.
  assign is_load = MEM_MemRead & ~MEM_MemWrite & ~misaligned;

  mem_wb u_mem_wb (
    .clk          (clk),
    .rst_n        (rst_n),
    .bubble       (stall),
    .hold         (~is_load),
    .mem_to_reg   (MEM_MemtoReg),
    .reg_write    (MEM_RegWrite & ~misaligned),
    .rdata        (dmem_rdata),
    .alu          (MEM_ALU),
    .dst          (MEM_Reg_Write),
    .WB_MemtoReg  (WB_MemtoReg),
    .WB_RegWrite  (WB_RegWrite),
    .WB_ReadData  (WB_ReadData),
    .WB_ALU       (WB_ALU),
    .WB_Reg_Write (WB_Reg_Write)
  );

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 Clocking and reset SHALL be one clock, clk, with synchronous active-low reset rst_n.
REQ-002 Ports (name  direction  width  meaning) SHALL be:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- MEM_MemtoReg, MEM_RegWrite, MEM_Branch, MEM_Jump, MEM_MemWrite, MEM_MemRead  in  1 each  control bits from the EX/MEM register
- MEM_PC  in  32  PC+4 of the instruction
- MEM_Jump_ins_add  in  26  jump index
- MEM_Zero  in  1  ALU zero flag
- MEM_ALU  in  32  ALU result / memory address
- MEM_WriteData  in  32  store data
- MEM_Extimm  in  32  sign-extended immediate
- MEM_Reg_Write  in  5  destination register
- dmem_req  out  1  data-memory request
- dmem_we  out  1  1 = write
- dmem_addr  out  32  byte address
- dmem_wdata  out  32  store data
- dmem_rdata  in  32  load data, valid when dmem_ack = 1
- dmem_ack  in  1  access complete
- stall  out  1  freeze PC, IF/ID, ID/EX and EX/MEM
- pc_src  out  1  redirect PC
- pc_target  out  32  redirect address
- flush  out  1  squash IF/ID and ID/EX
- WB_MemtoReg, WB_RegWrite  out  1 each  registered write-back control
- WB_ReadData, WB_ALU  out  32 each  registered load data and ALU result
- WB_Reg_Write  out  5  registered destination register
- mis_fault  out  1  misaligned-access flag (see REQ-016)

Function
REQ-003 mem_op SHALL equal MEM_MemRead | MEM_MemWrite; MemRead and MemWrite both high SHALL be treated as a write.
REQ-004 The FSM SHALL have exactly two states:
- IDLE to WAIT when mem_op & !dmem_ack.
- WAIT to IDLE on dmem_ack.
- All other cases hold the current state.
REQ-005 Memory request outputs:
- dmem_req SHALL equal mem_op (in both states) and hold until ack.
- dmem_we SHALL equal MEM_MemWrite.
- dmem_addr SHALL equal MEM_ALU.
- dmem_wdata SHALL equal MEM_WriteData.
- All four SHALL be combinational and stable while stalled.
REQ-006 stall SHALL equal mem_op & !dmem_ack (combinational); a zero-wait ack in the request cycle SHALL produce no stall.
REQ-007 Branch target SHALL be MEM_PC + (MEM_Extimm << 2), modulo 2^32 (wrap-around is not an error).
REQ-008 Jump target SHALL be {MEM_PC[31:28], MEM_Jump_ins_add, 2'b00}.
REQ-009 Redirect outputs:
- pc_src SHALL be 1 when !stall & (MEM_Jump | (MEM_Branch & MEM_Zero)).
- When pc_src is 1, pc_target SHALL be the jump target if MEM_Jump is 1, otherwise the branch target; Jump takes priority when both are set.
- flush SHALL equal pc_src.
REQ-010 On each rising edge with stall = 0, the WB register SHALL capture:
- WB_MemtoReg, WB_RegWrite, WB_Reg_Write from their MEM_* inputs.
- WB_ALU from MEM_ALU.
- WB_ReadData from dmem_rdata if MEM_MemRead, otherwise hold its previous value.
REQ-011 On each rising edge with stall = 1, the WB register SHALL load a bubble: WB_RegWrite = 0 and WB_MemtoReg = 0, other WB fields held.
REQ-012 Latency SHALL be one cycle from stall = 0 to WB valid; a load's data SHALL appear on WB_ReadData at the edge following the dmem_ack cycle.
REQ-013 A store SHALL produce exactly one dmem_req/ack transaction; the pipeline SHALL NOT re-issue it after ack.

Reset
REQ-014 With rst_n = 0 at a rising edge, the following SHALL be cleared, overriding any pending ack:
- state to IDLE
- all WB_* outputs to 0
- the registered mis_fault to 0
REQ-015 Reset asserted in WAIT SHALL abandon the access; a late dmem_ack after reset SHALL be ignored unless mem_op is set again.

Configuration
REQ-016 Macro MEM_ALIGN_CHECK_EN:
- Defined: when mem_op is 1 and MEM_ALU[1:0] != 0, dmem_req SHALL be 0, stall SHALL be 0, and WB_RegWrite SHALL be 0 at the next edge; mis_fault SHALL be 1 for that cycle (registered, so it rises one cycle later and lasts one cycle).
- Not defined: the address SHALL pass unchecked and mis_fault SHALL be tied to 0.

Structure
REQ-017 A shared package SHALL hold the FSM state typedef (IDLE, WAIT) and the constant JUMP_SHIFT = 2.
REQ-018 The WB register SHALL be a sub-module, mem_wb, with inputs for bubble insert and hold; the FSM, target calculation and redirect logic SHALL stay in mem_stage.

Verification
REQ-019 The bench SHALL cover these directed scenarios:
- Load, ack after 3 cycles, MEM_ALU=0x100, rdata=0xDEADBEEF -> stall=1 for 3 cycles, then WB_ReadData=0xDEADBEEF, WB_RegWrite=1.
- Store with ack in the same cycle -> stall never 1, exactly one dmem_req cycle with dmem_we=1.
- Branch with MEM_PC=0x40, Extimm=0xFFFFFFFF, Zero=1 -> pc_src=1, flush=1, pc_target=0x3C.
- Jump with Branch also set, MEM_PC=0x80000010, index=0x0000004 -> pc_target=0x80000010.
- Reset asserted mid-WAIT, then ack arrives -> state IDLE, WB_RegWrite=0, no capture.
- With MEM_ALIGN_CHECK_EN, load at 0x102 -> dmem_req=0, mis_fault=1 next cycle, WB_RegWrite=0.
